// File: rtl/imcorw_mix_apply_if.sv
// Bus bundle for imcorw_mix_apply: raw-quad write side, weight pop side and
// corrected-quad output. The DUT takes the slave view; the driver takes the master view.
interface imcorw_mix_apply_if #(
  parameter int DW_IN  = 10,
  parameter int DW_DEC = 8
);
  logic [1:0]          CFA;
  logic                vsync;
  logic                hsync;
  logic [4*DW_IN-1:0]  data_in;
  logic                w_valid;
  logic [DW_DEC:0]     imcorw_mixrb;
  logic                hsync_out;
  logic [4*DW_IN-1:0]  data_out;
  logic                fifo_ovf;
  logic                fifo_udf;

  modport master (
    output CFA, vsync, hsync, data_in, w_valid, imcorw_mixrb,
    input  hsync_out, data_out, fifo_ovf, fifo_udf
  );

  modport slave (
    input  CFA, vsync, hsync, data_in, w_valid, imcorw_mixrb,
    output hsync_out, data_out, fifo_ovf, fifo_udf
  );
endinterface

// File: rtl/imcorw_mix_apply.sv
// Over-exposure mix apply: buffers raw Bayer quads until their weight arrives,
// then blends R and B toward the green average by that weight (2-stage pipe).

// One colour lane of the blend: (w*g_avg + (1.0-w)*px + 0.5) >> DW_DEC.
module imcorw_mix_lane #(
  parameter int DW_IN  = 10,
  parameter int DW_DEC = 8
) (
  input  logic [DW_DEC:0]   w,
  input  logic [DW_IN-1:0]  g_avg,
  input  logic [DW_IN-1:0]  px,
  output logic [DW_IN-1:0]  px_out
);
  localparam int MW = DW_IN + DW_DEC + 2;

  logic [MW-1:0]       acc;
  logic [DW_DEC:0]     w_inv;
  logic [DW_DEC+1:0]   unused_bits;

  // Weighted sum with rounding; w <= 1.0 keeps the result within DW_IN bits.
  always_comb begin
    w_inv       = {1'b1, {DW_DEC{1'b0}}} - w;
    acc         = MW'(w) * MW'(g_avg) + MW'(w_inv) * MW'(px) + MW'(1 << (DW_DEC - 1));
    px_out      = acc[DW_DEC +: DW_IN];
    unused_bits = {acc[MW-1:DW_DEC+DW_IN], acc[DW_DEC-1:0]};
  end
endmodule

module imcorw_mix_apply #(
  parameter int DW_IN      = 10,
  parameter int DW_DEC     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  imcorw_mix_apply_if.slave bus
);
  localparam int QW     = 4 * DW_IN;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int WW     = DW_DEC + 1;
  localparam int STAGES = 2;
  localparam int NUM_LANES = 2;   // lane 0 = R, lane 1 = B
  localparam logic [WW-1:0] W_ONE = {1'b1, {DW_DEC{1'b0}}};
  localparam logic [AW:0]   FULL  = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [DW_IN-1:0] r;
    logic [DW_IN-1:0] g1;
    logic [DW_IN-1:0] g2;
    logic [DW_IN-1:0] b;
  } quad_t;

  // FIFO state
  logic              vsync_d1_q;
  logic              flush;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
  logic [AW:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_en, rd_en;
  logic [QW-1:0]     mem_q [FIFO_DEPTH];

  // Pipeline state
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  logic [3:0][DW_IN-1:0] sl;
  quad_t             q_pop, s1_q, s1_d;
  logic [DW_IN:0]    gsum;
  logic              unused_gsum;
  logic [DW_IN-1:0]  gavg_q, gavg_d;
  logic [WW-1:0]     w_q, w_d;
  logic [NUM_LANES-1:0][DW_IN-1:0] rb_in, rb_out;
  logic [QW-1:0]     dout_q, dout_d;

  // FIFO control: flush on vsync rise wins over reads; a coincident write lands in entry 0.
  always_comb begin
    flush    = bus.vsync & ~vsync_d1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    wr_addr  = wr_ptr_q;
    if (flush) begin
      wr_en    = bus.hsync;
      wr_addr  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = bus.hsync ? AW'(1) : '0;
      cnt_d    = bus.hsync ? (AW+1)'(1) : '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      rd_en = bus.w_valid & (cnt_q != '0);
      // a read in the same cycle frees the slot, so a write at full still lands
      wr_en = bus.hsync & ((cnt_q != FULL) | rd_en);
      if (bus.w_valid & (cnt_q == '0)) udf_d = 1'b1;
      if (bus.hsync & ~wr_en)          ovf_d = 1'b1;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  // FIFO pointers, count and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      vsync_d1_q <= bus.vsync;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Quad storage; contents are only meaningful below the count, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= bus.data_in;
  end

  // Stage 1: CFA demux of the popped quad, green average and weight clamp
  always_comb begin
    sl = mem_q[rd_ptr_q];
    case (bus.CFA)
      2'b00:   q_pop = '{r: sl[2], g1: sl[3], g2: sl[0], b: sl[1]};
      2'b01:   q_pop = '{r: sl[3], g1: sl[2], g2: sl[1], b: sl[0]};
      2'b10:   q_pop = '{r: sl[0], g1: sl[2], g2: sl[1], b: sl[3]};
      default: q_pop = '{r: sl[1], g1: sl[3], g2: sl[0], b: sl[2]};
    endcase
    gsum        = {1'b0, q_pop.g1} + {1'b0, q_pop.g2};
    unused_gsum = gsum[0];
    vld_pipe_d  = {vld_pipe_q[STAGES-1:1], rd_en};
    s1_d        = s1_q;
    gavg_d      = gavg_q;
    w_d         = w_q;
    if (rd_en) begin
      s1_d   = q_pop;
      gavg_d = gsum[DW_IN:1];
      w_d    = (bus.imcorw_mixrb > W_ONE) ? W_ONE : bus.imcorw_mixrb;
    end
  end

  // Per-lane R/B blend
  assign rb_in[0] = s1_q.r;
  assign rb_in[1] = s1_q.b;
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    imcorw_mix_lane #(.DW_IN(DW_IN), .DW_DEC(DW_DEC)) u_lane (
      .w      (w_q),
      .g_avg  (gavg_q),
      .px     (rb_in[l]),
      .px_out (rb_out[l])
    );
  end

  // Stage 2: repack in the input CFA order; output holds between pulses
  always_comb begin
    dout_d = dout_q;
    if (vld_pipe_q[1]) begin
      case (bus.CFA)
        2'b00:   dout_d = {s1_q.g1, rb_out[0], rb_out[1], s1_q.g2};
        2'b01:   dout_d = {rb_out[0], s1_q.g1, s1_q.g2, rb_out[1]};
        2'b10:   dout_d = {rb_out[1], s1_q.g1, s1_q.g2, rb_out[0]};
        default: dout_d = {s1_q.g1, rb_out[1], rb_out[0], s1_q.g2};
      endcase
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      gavg_q     <= '0;
      w_q        <= '0;
      dout_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      gavg_q     <= gavg_d;
      w_q        <= w_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.hsync_out = vld_pipe_q[STAGES];
  assign bus.data_out  = dout_q;
  assign bus.fifo_ovf  = ovf_q;
  assign bus.fifo_udf  = udf_q;
endmodule

// File: tb/tb_imcorw_mix_apply.sv
// Directed bench for imcorw_mix_apply: vector table for blend/CFA/clamp, plus
// hand sequences for reset, full, stream and flush. An expected-output pipe
// scores hsync_out/data_out every cycle.
module tb_imcorw_mix_apply;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imcorw_mix_apply_if #(.DW_IN(10), .DW_DEC(8)) bus ();
  imcorw_mix_apply #(.DW_IN(10), .DW_DEC(8), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [39:0] pack(input logic [1:0] c, input logic [9:0] r, g1, g2, b);
    case (c)
      2'b00:   return {g1, r, b, g2};
      2'b01:   return {r, g1, g2, b};
      2'b10:   return {b, g1, g2, r};
      default: return {g1, b, r, g2};
    endcase
  endfunction

  // Expected-output pipe: what was promised at the read, due two cycles later
  logic        exp_in_vld = 1'b0;
  logic [39:0] exp_in_dat = '0;
  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [39:0] p1_d = '0, p2_d = '0;
  logic [39:0] last_q = '0;
  logic        mon_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p1_d <= '0; p2_d <= '0;
    end else begin
      p1_v <= exp_in_vld; p1_d <= exp_in_dat;
      p2_v <= p1_v;       p2_d <= p1_d;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) last_q = '0;
    else if (p2_v) last_q = p2_d;
    if (mon_en) begin
      chk("hsync_out", 64'(bus.hsync_out), 64'(p2_v));
      chk("data_out", 64'(bus.data_out), 64'(last_q));
    end
  end

  task automatic cyc(input logic hs, input logic [39:0] din, input logic wv,
                     input logic [8:0] w, input logic ev, input logic [39:0] ed,
                     input logic vs);
    bus.hsync = hs; bus.data_in = din; bus.w_valid = wv; bus.imcorw_mixrb = w;
    bus.vsync = vs; exp_in_vld = ev; exp_in_dat = ed;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_flush();
    cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    idle(1);
  endtask

  function automatic logic [39:0] qf(input int i);
    return pack(2'b01, 10'(i*10+1), 10'(i*10+2), 10'(i*10+3), 10'(i*10+4));
  endfunction

  function automatic logic [39:0] qs(input int t);
    return pack(2'b01, 10'(t*7), 10'(t*3+1), 10'(1000-t), 10'(t*11));
  endfunction

  typedef struct {
    logic [1:0] cfa;
    logic [9:0] r, g1, g2, b;
    logic [8:0] w;
    logic [9:0] er, eb;
  } vec_t;
  vec_t vt[11];

  initial begin
    vt[0]  = '{2'd1, 10'd800,  10'd400, 10'd400, 10'd100, 9'd0,   10'd800, 10'd100};
    vt[1]  = '{2'd1, 10'd800,  10'd400, 10'd400, 10'd100, 9'd256, 10'd400, 10'd400};
    vt[2]  = '{2'd1, 10'd800,  10'd400, 10'd400, 10'd100, 9'd128, 10'd600, 10'd250};
    vt[3]  = '{2'd2, 10'd800,  10'd400, 10'd400, 10'd100, 9'd300, 10'd400, 10'd400};
    vt[4]  = '{2'd2, 10'd800,  10'd400, 10'd400, 10'd100, 9'd256, 10'd400, 10'd400};
    vt[5]  = '{2'd0, 10'd800,  10'd390, 10'd410, 10'd100, 9'd128, 10'd600, 10'd250};
    vt[6]  = '{2'd1, 10'd800,  10'd390, 10'd410, 10'd100, 9'd128, 10'd600, 10'd250};
    vt[7]  = '{2'd2, 10'd800,  10'd390, 10'd410, 10'd100, 9'd128, 10'd600, 10'd250};
    vt[8]  = '{2'd3, 10'd800,  10'd390, 10'd410, 10'd100, 9'd128, 10'd600, 10'd250};
    vt[9]  = '{2'd0, 10'd1023, 10'd401, 10'd402, 10'd0,   9'd64,  10'd868, 10'd100};
    vt[10] = '{2'd3, 10'd800,  10'd390, 10'd410, 10'd100, 9'd511, 10'd400, 10'd400};

    bus.CFA = 2'b01; bus.vsync = 1'b0; bus.hsync = 1'b0; bus.data_in = '0;
    bus.w_valid = 1'b0; bus.imcorw_mixrb = '0;

    // Reset with random activity on the inputs
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (4) cyc(1'($urandom()), 40'({$urandom(), $urandom()}), 1'($urandom()),
                   9'($urandom()), 1'b0, '0, 1'b0);
    chk("rst_ovf", 64'(bus.fifo_ovf), 64'd0);
    chk("rst_udf", 64'(bus.fifo_udf), 64'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    cyc(1'b0, '0, 1'b1, 9'd0, 1'b0, '0, 1'b0);
    chk("udf_after_rst", 64'(bus.fifo_udf), 64'd1);
    chk("ovf_after_rst", 64'(bus.fifo_ovf), 64'd0);
    idle(3);
    do_flush();
    chk("flush_clr_udf", 64'(bus.fifo_udf), 64'd0);

    // Blend / clamp / CFA vectors
    for (int i = 0; i < 11; i++) begin
      bus.CFA = vt[i].cfa;
      cyc(1'b1, pack(vt[i].cfa, vt[i].r, vt[i].g1, vt[i].g2, vt[i].b),
          1'b0, '0, 1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b1, vt[i].w, 1'b1,
          pack(vt[i].cfa, vt[i].er, vt[i].g1, vt[i].g2, vt[i].eb), 1'b0);
      idle(3);
    end
    chk("vec_udf", 64'(bus.fifo_udf), 64'd0);
    chk("vec_ovf", 64'(bus.fifo_ovf), 64'd0);

    // Full: 8 writes, dropped 9th, then read+write at full, then drain
    bus.CFA = 2'b01;
    do_flush();
    for (int i = 0; i < 8; i++) cyc(1'b1, qf(i), 1'b0, '0, 1'b0, '0, 1'b0);
    chk("full8_ovf", 64'(bus.fifo_ovf), 64'd0);
    cyc(1'b1, qf(8), 1'b0, '0, 1'b0, '0, 1'b0);
    chk("full9_ovf", 64'(bus.fifo_ovf), 64'd1);
    cyc(1'b1, qf(9), 1'b1, 9'd0, 1'b1, qf(0), 1'b0);
    for (int i = 1; i < 8; i++) cyc(1'b0, '0, 1'b1, 9'd0, 1'b1, qf(i), 1'b0);
    cyc(1'b0, '0, 1'b1, 9'd0, 1'b1, qf(9), 1'b0);
    chk("drain_udf_pre", 64'(bus.fifo_udf), 64'd0);
    cyc(1'b0, '0, 1'b1, 9'd0, 1'b0, '0, 1'b0);
    chk("drain_udf", 64'(bus.fifo_udf), 64'd1);
    idle(3);

    // Stream: 64 quads, each weight 7 cycles after its write
    do_flush();
    for (int t = 0; t < 71; t++) begin
      cyc(t < 64, (t < 64) ? qs(t) : 40'd0, t >= 7, 9'd0, t >= 7,
          (t >= 7) ? qs(t-7) : 40'd0, 1'b0);
    end
    idle(3);
    chk("stream_ovf", 64'(bus.fifo_ovf), 64'd0);
    chk("stream_udf", 64'(bus.fifo_udf), 64'd0);

    // Flush: count 5 + coincident write + ignored weight
    cyc(1'b0, '0, 1'b1, 9'd0, 1'b0, '0, 1'b0);
    chk("pre_flush_udf", 64'(bus.fifo_udf), 64'd1);
    for (int i = 0; i < 5; i++) cyc(1'b1, qf(i), 1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b1, qf(7), 1'b1, 9'd0, 1'b0, '0, 1'b1);
    chk("flush_udf", 64'(bus.fifo_udf), 64'd0);
    chk("flush_ovf", 64'(bus.fifo_ovf), 64'd0);
    cyc(1'b0, '0, 1'b1, 9'd0, 1'b1, qf(7), 1'b0);
    chk("flush_cnt1_udf", 64'(bus.fifo_udf), 64'd0);
    cyc(1'b0, '0, 1'b1, 9'd0, 1'b0, '0, 1'b0);
    chk("flush_empty_udf", 64'(bus.fifo_udf), 64'd1);
    idle(4);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/imcorw_mix_apply.md
# imcorw_mix_apply

Consumes the per-quad mixing weight from the over-exposure weight stage and applies it to the original Bayer quad. The quad is the 2x2 R/G1/G2/B group carried on `data_in`. The block buffers each raw quad until its weight arrives, then blends R and B toward the green average by that weight. It outputs the corrected quad in the input CFA order, so it sits directly downstream of the weight calculator in the over-exposure correction path.

## Interface
Parameters:
- `DW_IN`, 10: pixel width (integer).
- `DW_DEC`, 8: weight fraction bits. Weight is `DW_DEC+1` bits, and 1.0 = 256.
- `FIFO_DEPTH`, 8: raw-quad buffer depth. Must be a power of 2 and ≥ 8, which covers the 7-cycle weight-calculator latency.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `CFA`, in, 2: Bayer order, static per frame. 00 = G1 R B G2, 01 = R G1 G2 B, 10 = B G1 G2 R, 11 = G1 B R G2, listed MSB slice first.
- `vsync`, in, 1: frame sync. Its rising edge flushes the block.
- `hsync`, in, 1: `data_in` valid (write strobe).
- `data_in`, in, `4*DW_IN`: raw quad.
- `w_valid`, in, 1: weight valid (driven by the calculator's `hsync_out`).
- `imcorw_mixrb`, in, `DW_DEC+1`: weight, 0..256. Values above 256 are clamped to 256.
- `hsync_out`, out, 1: `data_out` valid pulse.
- `data_out`, out, `4*DW_IN`: corrected quad, same packing as `data_in`.
- `fifo_ovf`, out, 1: sticky overflow flag.
- `fifo_udf`, out, 1: sticky underflow flag.

## Operation
- **Reset:** `hsync_out`, `data_out`, `fifo_ovf` and `fifo_udf` are 0. Read/write pointers and the count are 0. All pipeline registers are 0.
- **FIFO write:** on `hsync=1`, store `data_in` at the write pointer, advance it modulo `FIFO_DEPTH`, and increment the count.
- **FIFO read:** on `w_valid=1`, pop the head entry together with the current `imcorw_mixrb`.
- **Full:** a write at count = `FIFO_DEPTH` with no simultaneous read is dropped and sets `fifo_ovf`. A simultaneous read and write at full both succeed, and the count is unchanged.
- **Empty:** a read at count = 0 sets `fifo_udf` and produces no output pulse. There is no bypass: a simultaneous write at empty is stored, so the count becomes 1.
- **Frame flush (vsync rising edge, `vsync=1` and `vsync_d1=0`):**
  - Clear pointers, count, `fifo_ovf` and `fifo_udf`.
  - A `w_valid` in the same cycle is ignored.
  - An `hsync` in the same cycle is stored at entry 0, so the count becomes 1.
  - Pipeline contents already past the FIFO still complete.
- **Stage 1 (registered):**
  - Demux the popped quad per `CFA` into r, g1, g2, b.
  - Compute `g_avg = (g1+g2)>>1`, with an (`DW_IN+1`)-bit sum truncated to `DW_IN`.
  - Compute `w = min(imcorw_mixrb, 256)`.
  - Carry g1, g2 and the valid bit.
- **Stage 2 (registered):**
  - `r_out = (w*g_avg + (256-w)*r + 128) >> 8`, with a 20-bit intermediate.
  - `b_out` uses the same formula with b.
  - g1 and g2 pass through unchanged.
  - The maximum result is 1023, so no output clamp is needed.
  - Repack per `CFA` into `data_out`.
- `data_out` holds its last value when `hsync_out=0`.
- `CFA` must be stable while the FIFO is non-empty. A change mid-frame is undefined.

## Timing
- Latency from a `w_valid` pop to `hsync_out`/`data_out` is 2 cycles. `w_valid` at cycle N gives `hsync_out` at N+2.
- Throughput is 1 quad/cycle. Back-to-back `w_valid` gives back-to-back `hsync_out`.
- Count and flags update on the same edge as the write/read. The flags become visible the cycle after the offending event.
- Asserting `rst_n` low mid-operation clears all state immediately (asynchronously). Quads in flight are lost.
- The first `hsync_out` after reset release needs at least one write followed by one `w_valid`.

## Test plan
- **Reset:** hold `rst_n=0` with random inputs -> all outputs 0. After release, `w_valid` alone -> `fifo_udf=1`, `hsync_out` stays 0.
- **Blend values:** CFA=01, quad R=800, G1=G2=400, B=100.
  - w=0 -> `data_out` R=800, B=100.
  - w=256 -> R=400, B=400.
  - w=128 -> R=600, B=250.
  - In all cases G1=G2=400, and `hsync_out` fires 2 cycles after `w_valid`.
- **Clamp and CFA:** CFA=10 with w=300 -> identical result to w=256. Repeat for all four CFA values and check the repacked slice positions.
- **Full:** 8 writes with no read, then a 9th write -> `fifo_ovf=1` and the 9th quad is discarded. Then a simultaneous read+write at full -> count stays 8 and output order is preserved.
- **Stream:** 64 quads, each `w_valid` 7 cycles after its `hsync` (matching the calculator latency) -> 64 `hsync_out` pulses in order, count never above 8, no flags.
- **Flush:** `vsync` rises with count=5 and a coincident `hsync` -> count=1, flags cleared. The next `w_valid` outputs the coincident quad.
